// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op and state encodings,
// default latencies and the op classifier.
package md_unit_pkg;

  localparam int unsigned CntW           = 4;
  localparam int unsigned DefMultCycles  = 5;
  localparam int unsigned DefDivCycles   = 10;

  typedef enum logic [2:0] {
    MdMult  = 3'd0,
    MdMultu = 3'd1,
    MdDiv   = 3'd2,
    MdDivu  = 3'd3,
    MdMthi  = 3'd4,
    MdMtlo  = 3'd5
  } md_op_e;

  typedef enum logic [0:0] {
    MdIdle = 1'b0,
    MdRun  = 1'b1
  } md_state_e;

  function automatic logic is_mul(logic [2:0] op);
    return (op == MdMult) || (op == MdMultu);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
interface md_unit_if;

  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, a, b, input busy, hi, lo);
  modport slave  (input start, md_op, a, b, output busy, hi, lo);

endinterface

// File: rtl/md_arith.sv
// Combinational 32x32 multiply/divide datapath producing the full HI/LO pair,
// including the divide-by-zero and signed-overflow results.
module md_arith
  import md_unit_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic        [31:0] safe_bs;
  logic        [31:0] safe_bu;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Divisors are steered to 1 in the special cases so the dividers never see
  // an undefined operation; the real results are substituted below.
  assign safe_bs = (div_zero || div_ovf) ? 32'd1 : b;
  assign safe_bu = div_zero ? 32'd1 : b;

  assign quo_s = $signed(a) / $signed(safe_bs);
  assign rem_s = $signed(a) % $signed(safe_bs);
  assign quo_u = a / safe_bu;
  assign rem_u = a % safe_bu;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op)
      MdMult: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MdMultu: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MdDiv: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      MdDivu: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: owns HI/LO, holds a computed result in shadow registers
// for a fixed latency, and reports busy while an operation is in flight.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DefMultCycles,
  parameter int unsigned DIV_CYCLES  = DefDivCycles
) (
  input  logic       clk,
  input  logic       reset_n,
  md_unit_if.slave   bus
);

  localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     shadow_hi_q, shadow_hi_d;
  logic [31:0]     shadow_lo_q, shadow_lo_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     res_hi;
  logic [31:0]     res_lo;

  md_arith u_arith (
    .md_op  (bus.md_op),
    .a      (bus.a),
    .b      (bus.b),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_hi_d = shadow_hi_q;
    shadow_lo_d = shadow_lo_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    unique case (state_q)
      MdIdle: begin
        if (bus.start) begin
          case (bus.md_op)
            MdMult, MdMultu, MdDiv, MdDivu: begin
              shadow_hi_d = res_hi;
              shadow_lo_d = res_lo;
              cnt_d       = is_mul(bus.md_op) ? MultCnt : DivCnt;
              state_d     = MdRun;
            end
            MdMthi:  hi_d = bus.a;
            MdMtlo:  lo_d = bus.a;
            default: ;
          endcase
        end
      end
      MdRun: begin
        // Any start seen here is dropped; the hazard unit should never send one.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          hi_d    = shadow_hi_q;
          lo_d    = shadow_lo_q;
          state_d = MdIdle;
        end
      end
      default: state_d = MdIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= MdIdle;
      cnt_q       <= '0;
      shadow_hi_q <= '0;
      shadow_lo_q <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_hi_q <= shadow_hi_d;
      shadow_lo_q <= shadow_lo_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign bus.busy = (state_q == MdRun);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, arithmetic corner cases, ignored issues
// while busy, back-to-back issue and asynchronous reset mid-operation.
module tb_md_unit;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   nbusy;
  int   held;

  md_unit_if bus ();

  md_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one mult/div, count busy cycles and note whether HI/LO held meanwhile.
  task automatic run_op(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi    = bus.hi;
    old_lo    = bus.lo;
    bus.start = 1'b1;
    bus.md_op = op;
    bus.a     = va;
    bus.b     = vb;
    tick();
    bus.start = 1'b0;
    nbusy     = 0;
    held      = 1;
    while (bus.busy === 1'b1 && nbusy < 40) begin
      nbusy++;
      if (bus.hi !== old_hi || bus.lo !== old_lo) held = 0;
      tick();
    end
  endtask

  task automatic pulse(input logic [2:0] op, input logic [31:0] va);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.a     = va;
    bus.b     = 32'd0;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.md_op = 3'd7;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    tick();
    tick();
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    reset_n = 1'b1;
    tick();

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_busy_cycles", nbusy, 32'd5);
    chk("mult_hold_while_busy", held, 32'd1);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFEB);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_busy_cycles", nbusy, 32'd5);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);

    run_op(3'd3, 32'd100, 32'd7);
    chk("divu_busy_cycles", nbusy, 32'd10);
    chk("divu_hold_while_busy", held, 32'd1);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", bus.hi, 32'hFFFF_FFFF);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo", bus.lo, 32'h8000_0000);
    chk("div_ovf_hi", bus.hi, 32'd0);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("divu_big_lo", bus.lo, 32'd0);
    chk("divu_big_hi", bus.hi, 32'h8000_0000);

    run_op(3'd3, 32'd5, 32'd0);
    chk("divu_zero_busy_cycles", nbusy, 32'd10);
    chk("divu_zero_lo", bus.lo, 32'hFFFF_FFFF);
    chk("divu_zero_hi", bus.hi, 32'd5);

    run_op(3'd2, 32'hFFFF_FFF7, 32'd0);
    chk("div_zero_busy_cycles", nbusy, 32'd10);
    chk("div_zero_lo", bus.lo, 32'hFFFF_FFFF);
    chk("div_zero_hi", bus.hi, 32'hFFFF_FFF7);

    pulse(3'd4, 32'h0000_1234);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    chk("mthi_hi", bus.hi, 32'h0000_1234);
    chk("mthi_lo_kept", bus.lo, 32'hFFFF_FFFF);
    tick();
    chk("mthi_busy_later", {31'd0, bus.busy}, 32'd0);

    pulse(3'd5, 32'h0000_5678);
    chk("mtlo_lo", bus.lo, 32'h0000_5678);
    chk("mtlo_hi_kept", bus.hi, 32'h0000_1234);

    pulse(3'd6, 32'hDEAD_BEEF);
    chk("nop6_busy", {31'd0, bus.busy}, 32'd0);
    chk("nop6_hi", bus.hi, 32'h0000_1234);
    chk("nop6_lo", bus.lo, 32'h0000_5678);

    // DIV 20/3 with a MULT and an MTLO thrown at it mid-run.
    bus.start = 1'b1;
    bus.md_op = 3'd2;
    bus.a     = 32'd20;
    bus.b     = 32'd3;
    tick();
    bus.start = 1'b0;
    nbusy     = 0;
    while (bus.busy === 1'b1 && nbusy < 40) begin
      nbusy++;
      bus.start = 1'b0;
      if (nbusy == 2) begin
        bus.start = 1'b1;
        bus.md_op = 3'd0;
        bus.a     = 32'd2;
        bus.b     = 32'd2;
      end
      if (nbusy == 4) begin
        bus.start = 1'b1;
        bus.md_op = 3'd5;
        bus.a     = 32'h0000_AAAA;
      end
      if (nbusy == 3 || nbusy == 5) begin
        chk("ignored_hi_kept", bus.hi, 32'h0000_1234);
        chk("ignored_lo_kept", bus.lo, 32'h0000_5678);
      end
      tick();
    end
    bus.start = 1'b0;
    chk("ignored_busy_cycles", nbusy, 32'd10);
    chk("ignored_div_lo", bus.lo, 32'd6);
    chk("ignored_div_hi", bus.hi, 32'd2);

    // First idle cycle after completion: issue immediately.
    run_op(3'd0, 32'd6, 32'd7);
    chk("b2b_busy_cycles", nbusy, 32'd5);
    chk("b2b_lo", bus.lo, 32'd42);
    chk("b2b_hi", bus.hi, 32'd0);

    // Asynchronous reset in the third busy cycle of a MULT.
    run_op(3'd1, 32'd9, 32'd9);
    chk("pre_reset_lo", bus.lo, 32'd81);
    bus.start = 1'b1;
    bus.md_op = 3'd0;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("async_reset_hi", bus.hi, 32'd0);
    chk("async_reset_lo", bus.lo, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("post_reset_idle", {31'd0, bus.busy}, 32'd0);
    chk("post_reset_lo", bus.lo, 32'd0);

    run_op(3'd1, 32'd3, 32'd4);
    chk("post_reset_busy_cycles", nbusy, 32'd5);
    chk("post_reset_hold", held, 32'd1);
    chk("post_reset_mult_lo", bus.lo, 32'd12);
    chk("post_reset_mult_hi", bus.hi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
